// File: rtl/flipper_multi_block.sv
// Multi-mode flipper controller: owns paddle position, speed and dual-mode gap,
// updates once per frame, and produces the registered paddle draw mask and colour.
module flipper_multi_block #(
  parameter int FLIPPER_WIDTH_X  = 64,
  parameter int FLIPPER_HEIGHT_Y = 16,
  parameter int FLIPPER_Y        = 440,
  parameter int CENTER_X         = 320,
  parameter int LEFT_BOUND       = 32,
  parameter int RIGHT_BOUND      = 608,
  parameter int MAX_SPEED        = 8,
  parameter int ACCEL            = 1,
  parameter int MAX_GAP          = 64,
  parameter int GAP_STEP         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        keyLeft,
  input  logic        keyRight,
  input  logic        keySplit,
  input  logic        pause,
  input  logic        reset_level,
  input  logic [1:0]  modeSel,
  output logic [7:0]  RGB_flipper,
  output logic        drawFlipper,
  output logic [31:0] speedX,
  output logic [10:0] posX,
  output logic [1:0]  modeActive
);

  localparam int SPEED_W     = 12;
  localparam int HOME_X      = CENTER_X - FLIPPER_WIDTH_X / 2;
  localparam int WIDE_HOME_X = CENTER_X - FLIPPER_WIDTH_X;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_DUAL   = 2'd1,
    MODE_WIDE   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  mode_e                     mode_q, mode_d;
  logic [10:0]               posx_q, posx_d;
  logic signed [SPEED_W-1:0] speed_q, speed_d;
  logic [10:0]               gap_q, gap_d;
  logic                      draw_q;
  logic [7:0]                rgb_q;

  mode_e mode_req;
  logic  mode_change;
  int    width_cur;
  int    spd_next;
  int    pos_sum;
  int    gap_next;

  assign mode_req    = mode_e'(modeSel);
  assign mode_change = (mode_req != MODE_RSVD) && (mode_req != mode_q);
  assign width_cur   = (mode_q == MODE_WIDE) ? 2 * FLIPPER_WIDTH_X : FLIPPER_WIDTH_X;

  // Candidate motion for this frame, before clamping against the frame edges.
  always_comb begin
    spd_next = int'(speed_q);
    if (keyRight && !keyLeft)
      spd_next = (spd_next + ACCEL > MAX_SPEED) ? MAX_SPEED : spd_next + ACCEL;
    else if (keyLeft && !keyRight)
      spd_next = (spd_next - ACCEL < -MAX_SPEED) ? -MAX_SPEED : spd_next - ACCEL;
    else if (spd_next > 0)
      spd_next = (spd_next > ACCEL) ? spd_next - ACCEL : 0;
    else if (spd_next < 0)
      spd_next = (spd_next < -ACCEL) ? spd_next + ACCEL : 0;
    pos_sum = int'(posx_q) + spd_next;
    if (keySplit)
      gap_next = (int'(gap_q) + GAP_STEP > MAX_GAP) ? MAX_GAP : int'(gap_q) + GAP_STEP;
    else
      gap_next = (int'(gap_q) < GAP_STEP) ? 0 : int'(gap_q) - GAP_STEP;
  end

  always_comb begin
    mode_d  = mode_q;
    posx_d  = posx_q;
    speed_d = speed_q;
    gap_d   = gap_q;
    if (reset_level) begin
      if (mode_req != MODE_RSVD) mode_d = mode_req;
      posx_d  = 11'(HOME_X);
      speed_d = '0;
      gap_d   = '0;
    end else if (!pause && startOfFrame) begin
      if (mode_change) begin
        mode_d  = mode_req;
        posx_d  = (mode_req == MODE_WIDE) ? 11'(WIDE_HOME_X) : 11'(HOME_X);
        speed_d = '0;
        gap_d   = '0;
      end else if (mode_q == MODE_DUAL) begin
        speed_d = '0;
        gap_d   = 11'(gap_next);
      end else if (pos_sum < LEFT_BOUND) begin
        posx_d  = 11'(LEFT_BOUND);
        speed_d = '0;
      end else if (pos_sum > RIGHT_BOUND - width_cur) begin
        posx_d  = 11'(RIGHT_BOUND - width_cur);
        speed_d = '0;
      end else begin
        posx_d  = 11'(pos_sum);
        speed_d = SPEED_W'(spd_next);
      end
    end
  end

  // Half 0 is the single/wide paddle or the left dual half; half 1 exists only in dual mode.
  logic signed [31:0] lo_x [2];
  logic signed [31:0] hi_x [2];
  logic [1:0]         hit_x;
  logic               hit_y;
  logic               hit;
  logic [7:0]         colour;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      if (gi == 0) begin : g_left
        assign lo_x[gi] = (mode_q == MODE_DUAL) ? CENTER_X - int'(gap_q) - FLIPPER_WIDTH_X
                                                : int'(posx_q);
        assign hi_x[gi] = (mode_q == MODE_DUAL) ? CENTER_X - int'(gap_q)
                                                : int'(posx_q) + width_cur;
      end else begin : g_right
        assign lo_x[gi] = CENTER_X + int'(gap_q);
        assign hi_x[gi] = (mode_q == MODE_DUAL) ? CENTER_X + int'(gap_q) + FLIPPER_WIDTH_X
                                                : CENTER_X + int'(gap_q);
      end
      assign hit_x[gi] = (int'(pixelX) >= lo_x[gi]) && (int'(pixelX) < hi_x[gi]);
    end
  endgenerate

  assign hit_y = (int'(pixelY) >= FLIPPER_Y) && (int'(pixelY) < FLIPPER_Y + FLIPPER_HEIGHT_Y);
  assign hit   = hit_y && (|hit_x);

  always_comb begin
    colour = 8'hFF;
    case (mode_q)
      MODE_DUAL: colour = 8'h1C;
      MODE_WIDE: colour = 8'hE0;
      default:   colour = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_SINGLE;
      posx_q  <= 11'(HOME_X);
      speed_q <= '0;
      gap_q   <= '0;
      draw_q  <= 1'b0;
      rgb_q   <= 8'h00;
    end else begin
      mode_q  <= mode_d;
      posx_q  <= posx_d;
      speed_q <= speed_d;
      gap_q   <= gap_d;
      draw_q  <= hit;
      rgb_q   <= hit ? colour : 8'h00;
    end
  end

  assign drawFlipper = draw_q;
  assign RGB_flipper = rgb_q;
  assign speedX      = {{(32 - SPEED_W){speed_q[SPEED_W-1]}}, speed_q};
  assign posX        = posx_q;
  assign modeActive  = mode_q;

endmodule

// File: tb/tb_flipper_multi_block.sv
// Directed bench for flipper_multi_block: per-feature tasks with hand-computed
// expected positions, speeds and draw results.
module tb_flipper_multi_block;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        keyLeft = 1'b0;
  logic        keyRight = 1'b0;
  logic        keySplit = 1'b0;
  logic        pause = 1'b0;
  logic        reset_level = 1'b0;
  logic [1:0]  modeSel = 2'd0;
  logic [7:0]  RGB_flipper;
  logic        drawFlipper;
  logic [31:0] speedX;
  logic [10:0] posX;
  logic [1:0]  modeActive;

  int vectors = 0;
  int miscompares = 0;

  flipper_multi_block dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .keyLeft(keyLeft), .keyRight(keyRight),
    .keySplit(keySplit), .pause(pause), .reset_level(reset_level),
    .modeSel(modeSel), .RGB_flipper(RGB_flipper), .drawFlipper(drawFlipper),
    .speedX(speedX), .posX(posX), .modeActive(modeActive)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic set_pixel(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
  endtask

  task automatic test_reset();
    int px [5] = '{288, 351, 352, 287, 288};
    int py [5] = '{440, 455, 440, 440, 456};
    logic ed [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    vectors++;
    if (posX !== 11'd288 || speedX !== 32'd0 || modeActive !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: posX=%0d speedX=%0d mode=%0d, expected 288/0/0", posX, speedX, modeActive);
    end
    for (int i = 0; i < 5; i++) begin
      set_pixel(px[i], py[i]);
      vectors++;
      if (drawFlipper !== ed[i] || RGB_flipper !== (ed[i] ? 8'hFF : 8'h00)) begin
        miscompares++;
        $display("FAIL reset_draw (%0d,%0d): draw=%0b rgb=%h, expected %0b/%h",
                 px[i], py[i], drawFlipper, RGB_flipper, ed[i], ed[i] ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic test_accel();
    int exp_spd [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 7, 6, 5, 4, 3};
    int exp_pos [15] = '{289, 291, 294, 298, 303, 309, 316, 324, 332, 340, 347, 353, 358, 362, 365};
    for (int i = 0; i < 15; i++) begin
      keyRight = (i < 10) || (i >= 13);
      keyLeft  = (i >= 13);
      frame();
      vectors++;
      if (speedX !== 32'(exp_spd[i]) || posX !== 11'(exp_pos[i])) begin
        miscompares++;
        $display("FAIL accel frame %0d: speedX=%0d posX=%0d, expected %0d/%0d",
                 i, $signed(speedX), posX, exp_spd[i], exp_pos[i]);
      end
    end
  endtask

  task automatic test_clamp();
    keyLeft = 1'b0;
    keyRight = 1'b1;
    repeat (60) frame();
    vectors++;
    if (posX !== 11'd544 || speedX !== 32'd0) begin
      miscompares++;
      $display("FAIL clamp_right: posX=%0d speedX=%0d, expected 544/0", posX, $signed(speedX));
    end
    keyRight = 1'b0;
    keyLeft = 1'b1;
    repeat (100) frame();
    vectors++;
    if (posX !== 11'd32 || speedX !== 32'd0) begin
      miscompares++;
      $display("FAIL clamp_left: posX=%0d speedX=%0d, expected 32/0", posX, $signed(speedX));
    end
    keyLeft = 1'b0;
  endtask

  task automatic test_mode_latch();
    int px [8] = '{255, 256, 383, 384, 447, 448, 192, 191};
    logic ed [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    modeSel = 2'd1;
    repeat (3) tick();
    vectors++;
    if (modeActive !== 2'd0) begin
      miscompares++;
      $display("FAIL latch_wait: modeActive=%0d, expected 0", modeActive);
    end
    keyRight = 1'b1;
    frame();
    keyRight = 1'b0;
    vectors++;
    if (modeActive !== 2'd1 || speedX !== 32'd0) begin
      miscompares++;
      $display("FAIL latch_dual: modeActive=%0d speedX=%0d, expected 1/0", modeActive, $signed(speedX));
    end
    keySplit = 1'b1;
    repeat (16) frame();
    for (int i = 0; i < 8; i++) begin
      set_pixel(px[i], 440);
      vectors++;
      if (drawFlipper !== ed[i] || RGB_flipper !== (ed[i] ? 8'h1C : 8'h00)) begin
        miscompares++;
        $display("FAIL dual_gap64 x=%0d: draw=%0b rgb=%h, expected %0b/%h",
                 px[i], drawFlipper, RGB_flipper, ed[i], ed[i] ? 8'h1C : 8'h00);
      end
    end
    keySplit = 1'b0;
    frame();
    set_pixel(259, 440);
    vectors++;
    if (drawFlipper !== 1'b1) begin
      miscompares++;
      $display("FAIL dual_gap60 x=259: draw=%0b, expected 1", drawFlipper);
    end
    set_pixel(260, 440);
    vectors++;
    if (drawFlipper !== 1'b0) begin
      miscompares++;
      $display("FAIL dual_gap60 x=260: draw=%0b, expected 0", drawFlipper);
    end
  endtask

  task automatic test_wide();
    int px [4] = '{256, 383, 384, 255};
    logic ed [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    modeSel = 2'd2;
    frame();
    vectors++;
    if (modeActive !== 2'd2 || posX !== 11'd256 || speedX !== 32'd0) begin
      miscompares++;
      $display("FAIL wide_latch: mode=%0d posX=%0d speedX=%0d, expected 2/256/0",
               modeActive, posX, $signed(speedX));
    end
    for (int i = 0; i < 4; i++) begin
      set_pixel(px[i], 447);
      vectors++;
      if (drawFlipper !== ed[i] || RGB_flipper !== (ed[i] ? 8'hE0 : 8'h00)) begin
        miscompares++;
        $display("FAIL wide_draw x=%0d: draw=%0b rgb=%h, expected %0b/%h",
                 px[i], drawFlipper, RGB_flipper, ed[i], ed[i] ? 8'hE0 : 8'h00);
      end
    end
    keyRight = 1'b1;
    repeat (40) frame();
    keyRight = 1'b0;
    vectors++;
    if (posX !== 11'd480 || speedX !== 32'd0) begin
      miscompares++;
      $display("FAIL wide_clamp: posX=%0d speedX=%0d, expected 480/0", posX, $signed(speedX));
    end
  endtask

  task automatic test_priority();
    int px [3] = '{319, 383, 384};
    logic ed [3] = '{1'b1, 1'b1, 1'b0};
    modeSel = 2'd0;
    reset_level = 1'b1;
    tick();
    reset_level = 1'b0;
    keyLeft = 1'b1;
    repeat (3) frame();
    keyLeft = 1'b0;
    pause = 1'b1;
    keyRight = 1'b1;
    repeat (5) frame();
    vectors++;
    if (posX !== 11'd282 || speedX !== 32'hFFFF_FFFD || modeActive !== 2'd0) begin
      miscompares++;
      $display("FAIL pause_hold: posX=%0d speedX=%0d mode=%0d, expected 282/-3/0",
               posX, $signed(speedX), modeActive);
    end
    set_pixel(282, 440);
    vectors++;
    if (drawFlipper !== 1'b1 || RGB_flipper !== 8'hFF) begin
      miscompares++;
      $display("FAIL pause_draw: draw=%0b rgb=%h, expected 1/ff", drawFlipper, RGB_flipper);
    end
    modeSel = 2'd1;
    reset_level = 1'b1;
    frame();
    reset_level = 1'b0;
    pause = 1'b0;
    vectors++;
    if (posX !== 11'd288 || speedX !== 32'd0 || modeActive !== 2'd1) begin
      miscompares++;
      $display("FAIL level_restart: posX=%0d speedX=%0d mode=%0d, expected 288/0/1",
               posX, $signed(speedX), modeActive);
    end
    frame();
    keyRight = 1'b0;
    vectors++;
    if (speedX !== 32'd0 || posX !== 11'd288) begin
      miscompares++;
      $display("FAIL dual_nomove: speedX=%0d posX=%0d, expected 0/288", $signed(speedX), posX);
    end
    for (int i = 0; i < 3; i++) begin
      set_pixel(px[i], 440);
      vectors++;
      if (drawFlipper !== ed[i] || RGB_flipper !== (ed[i] ? 8'h1C : 8'h00)) begin
        miscompares++;
        $display("FAIL dual_gap0 x=%0d: draw=%0b rgb=%h, expected %0b/%h",
                 px[i], drawFlipper, RGB_flipper, ed[i], ed[i] ? 8'h1C : 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_pixel(320, 440);
    vectors++;
    if (drawFlipper !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_draw: draw=%0b, expected 1", drawFlipper);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (drawFlipper !== 1'b0 || RGB_flipper !== 8'h00 || modeActive !== 2'd0 || posX !== 11'd288) begin
      miscompares++;
      $display("FAIL mid_reset: draw=%0b rgb=%h mode=%0d posX=%0d, expected 0/00/0/288",
               drawFlipper, RGB_flipper, modeActive, posX);
    end
    modeSel = 2'd3;
    keyRight = 1'b1;
    frame();
    keyRight = 1'b0;
    vectors++;
    if (modeActive !== 2'd0 || speedX !== 32'd1 || posX !== 11'd289) begin
      miscompares++;
      $display("FAIL reserved_mode: mode=%0d speedX=%0d posX=%0d, expected 0/1/289",
               modeActive, $signed(speedX), posX);
    end
    set_pixel(320, 440);
    vectors++;
    if (drawFlipper !== 1'b1 || RGB_flipper !== 8'hFF) begin
      miscompares++;
      $display("FAIL reserved_draw: draw=%0b rgb=%h, expected 1/ff", drawFlipper, RGB_flipper);
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_clamp();
    test_mode_latch();
    test_wide();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flipper_multi_block.md
# flipper_multi_block

Parametrised, multi-mode flipper controller for the main screen: next generation of the single/dual flipper pair. It owns paddle position and velocity across frames, with frame-rate acceleration and decay, boundary clamping, an animated split gap in dual mode, and a wide mode. It latches mode changes only at frame boundaries. It feeds the main-screen draw mux (`RGB_flipper`, `drawFlipper`) and the ball physics (`speedX`).

## Interface
- `FLIPPER_WIDTH_X`, 64: paddle width, in pixels. Wide mode uses 2× this value.
- `FLIPPER_HEIGHT_Y`, 16: paddle height, in pixels.
- `FLIPPER_Y`, 440: top row of the paddle.
- `CENTER_X`, 320: screen centre column.
- `LEFT_BOUND`, 32 / `RIGHT_BOUND`, 608: inner frame edges. The paddle occupies [`LEFT_BOUND`, `RIGHT_BOUND`).
- `MAX_SPEED`, 8: speed magnitude limit, in pixels per frame.
- `ACCEL`, 1: speed change per frame.
- `MAX_GAP`, 64 / `GAP_STEP`, 4: dual-mode half-gap limit and its step per frame.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high reset.
- `pixelX`, `pixelY` in 11 each: current scan pixel.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `keyLeft`, `keyRight`, `keySplit` in 1 each: level-sensitive key states.
- `pause` in 1: freezes all state.
- `reset_level` in 1: level restart.
- `modeSel` in 2: 0 = single, 1 = dual, 2 = wide, 3 = reserved.
- `RGB_flipper` out 8: pixel colour.
- `drawFlipper` out 1: the current pixel lies inside a paddle.
- `speedX` out 32: signed horizontal speed, two's complement.
- `posX` out 11: left edge of the single/wide paddle.
- `modeActive` out 2: currently latched mode.

## Operation
- State registers: `mode`, `posX`, `speed` (signed), `gap` (0..`MAX_GAP`).
- Update priority per clock: `reset` > `reset_level` > `pause` > `startOfFrame` update > hold.
- **`reset`:**
  - `mode` = 0, `posX` = `CENTER_X` − `FLIPPER_WIDTH_X`/2 (288), `speed` = 0, `gap` = 0.
  - `drawFlipper` = 0, `RGB_flipper` = 0.
- **`reset_level`:**
  - Same position, speed and gap values as `reset`.
  - `mode` is loaded from `modeSel`; the current value is kept if `modeSel` = 3.
- **`pause`:** state is held, including through `startOfFrame`. Drawing continues from the held state.
- **Frame update**, on `startOfFrame` when not paused:
  1. Mode latch. If `modeSel` ≠ 3 and `modeSel` ≠ `mode`:
     - `mode` ← `modeSel`.
     - `posX` ← centred for the new width, `speed` ← 0, `gap` ← 0.
     - No motion is applied this frame.
  2. Speed, single/wide modes:
     - `keyRight` only: `speed` += `ACCEL`, saturating at +`MAX_SPEED`.
     - `keyLeft` only: `speed` −= `ACCEL`, saturating at −`MAX_SPEED`.
     - Neither or both: `speed` moves toward 0 by `ACCEL`, never crossing 0.
  3. Position: `posX` ← `posX` + new `speed`, computed in signed 13-bit arithmetic. W = current width.
     - If the result is < `LEFT_BOUND`: `posX` = `LEFT_BOUND`, `speed` = 0.
     - If the result is > `RIGHT_BOUND` − W: `posX` = `RIGHT_BOUND` − W, `speed` = 0.
  4. Dual mode:
     - `speed` forced to 0; `posX` unchanged.
     - `keySplit` held: `gap` += `GAP_STEP`, saturating at `MAX_GAP`.
     - `keySplit` released: `gap` −= `GAP_STEP`, saturating at 0.
- **Draw regions.** Rows are always [`FLIPPER_Y`, `FLIPPER_Y` + H).
  - Single: columns [`posX`, `posX` + W).
  - Wide: columns [`posX`, `posX` + 2W).
  - Dual: columns [`CENTER_X` − `gap` − W, `CENTER_X` − `gap`) ∪ [`CENTER_X` + `gap`, `CENTER_X` + `gap` + W).
- **Colour:** single 8'hFF, dual 8'h1C, wide 8'hE0. `RGB_flipper` = 0 whenever `drawFlipper` = 0.
- `speedX` = sign-extended `speed` in single/wide mode; 0 in dual mode.

## Timing
- `drawFlipper` and `RGB_flipper` are registered: one clk of latency from `pixelX`/`pixelY`. They are evaluated against the state as of that same edge.
- `speedX`, `posX` and `modeActive` change only on the clk edge that samples `startOfFrame`, `reset_level` or `reset`. Each is a direct register output.
- A `modeSel` change between `startOfFrame` pulses has no effect until the next pulse.
- If `startOfFrame` coincides with `reset_level`, only the restart happens (no motion).
- If `startOfFrame` coincides with `pause`, no update happens.
- A `reset` asserted mid-frame takes effect on the next edge. Draw outputs are 0 on the following cycle.

## Test plan
- **Reset values:** assert `reset` for 2 clk → `posX` = 288, `speedX` = 0, `modeActive` = 0. Pixel (288,440) → `drawFlipper` = 1, `RGB_flipper` = 8'hFF one clk later. Pixel (288,456) → 0.
- **Acceleration and decay:** hold `keyRight` for 10 frames → `speedX` reads 1..8, 8, 8 and `posX` = 340. Release for 3 frames → `speedX` = 7, 6, 5 and `posX` = 358. Holding both keys continues the decay.
- **Clamp:** hold `keyRight` for 60 frames → `posX` saturates at 544, with `speedX` = 0 on the clamping frame. Hold `keyLeft` → `posX` bottoms at 32.
- **Mode latch:** set `modeSel` = 1 mid-frame → `modeActive` stays 0 until the next `startOfFrame`, then becomes 1 with `speedX` = 0. Hold `keySplit` 16 frames → `gap` = 64. Column 255 draws, columns 256..383 do not, column 384 draws; all at row 440.
- **Wide mode:** `modeSel` = 2 → `posX` = 256 and `RGB_flipper` = 8'hE0 over columns 256..383. Hold `keyRight` → `posX` clamps at 480.
- **Priority:** `pause` held with `keyRight` across 5 frames → state is unchanged. Then `reset_level` together with `startOfFrame` and `pause` → `posX` = 288, `speed` = 0, `gap` = 0, mode loaded from `modeSel`.
